// File: rtl/dm_sized.sv
// dm_sized: byte-addressable MEM-stage data memory with valid/ready request port and LATENCY-edge response.
// Ports: clk, reset (sync, active-high); req_valid/req_ready handshake with req_we, req_addr, req_size
// (00 byte, 01 half, 10 word), req_sign, req_wdata, req_pc; resp_valid pulse with resp_rdata, resp_exc.
module dm_sized #(
    parameter int ADDR_W  = 14,
    parameter int LATENCY = 1,
    parameter int TRACE   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_exc
);
    localparam int CW = $clog2(LATENCY + 1);
    localparam int NW = 2 ** (ADDR_W - 2);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t          state;
    logic [CW-1:0]   cnt;
    logic [31:0]     mem [NW];
    logic [31:0]     rdata_q, pend_rdata, word, shifted, wrep, merged, ld;
    logic            exc_q, pend_exc, fault, accept;
    logic [3:0]      be;
    logic [ADDR_W-3:0] widx;
    assign req_ready  = !reset && (state == IDLE || state == RESP);
    assign resp_valid = state == RESP;
    assign resp_rdata = rdata_q;
    assign resp_exc   = exc_q;
    assign accept     = req_valid && req_ready;
    assign widx       = req_addr[ADDR_W-1:2];
    always_comb begin
        word    = mem[widx];
        fault   = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
                  (req_size == 2'b10 && req_addr[1:0] != 2'b00) || (req_addr >> ADDR_W) != 32'd0;
        shifted = word >> {req_addr[1:0], 3'b000};
        ld      = (fault || req_we) ? 32'd0 :
                  req_size == 2'b00 ? {{24{req_sign & shifted[7]}}, shifted[7:0]} :
                  req_size == 2'b01 ? {{16{req_sign & shifted[15]}}, shifted[15:0]} : word;
        be      = req_size == 2'b00 ? 4'b0001 << req_addr[1:0] :
                  req_size == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wrep    = req_size == 2'b00 ? {4{req_wdata[7:0]}} :
                  req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
        merged  = word;
        for (int i = 0; i < 4; i++) if (be[i]) merged[i*8+:8] = wrep[i*8+:8];
    end
    // The pending registers hold a new result while an older response is still presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            rdata_q    <= '0;
            exc_q      <= 1'b0;
            pend_rdata <= '0;
            pend_exc   <= 1'b0;
            for (int i = 0; i < NW; i++) mem[i] <= '0;
        end else if (accept) begin
            cnt        <= CW'(LATENCY - 1);
            state      <= LATENCY == 1 ? RESP : BUSY;
            pend_rdata <= ld;
            pend_exc   <= fault;
            if (LATENCY == 1) begin
                rdata_q <= ld;
                exc_q   <= fault;
            end
            if (req_we && !fault) mem[widx] <= merged;
        end else if (state == BUSY) begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
                state   <= RESP;
                rdata_q <= pend_rdata;
                exc_q   <= pend_exc;
            end
        end else if (state == RESP) begin
            state <= IDLE;
        end
    end
`ifndef SYNTHESIS
    always_ff @(posedge clk)
        if (TRACE != 0 && accept && req_we && !fault)
            $display("%d@%h: *%h <= %h", $time, req_pc, {req_addr[31:2], 2'b00}, merged);
`endif
endmodule

// File: tb/tb_dm_sized.sv
// tb_dm_sized: randomized and directed self-checking bench for dm_sized at LATENCY 1 and 3.
module tb_dm_sized;
    logic clk = 0, reset = 1;
    always #5 clk = ~clk;
    logic        v1 = 0, v3 = 0, we = 0, sg = 0;
    logic [31:0] a = 0, wd = 0, pc = 0;
    logic [1:0]  sz = 0;
    logic        r1, r3, rv1, rv3, e1, e3;
    logic [31:0] d1, d3;
    int total = 0, bad = 0;
    logic [7:0] m1 [16384];
    logic [7:0] m3 [16384];

    dm_sized #(.ADDR_W(14), .LATENCY(1), .TRACE(1)) u1 (
        .clk(clk), .reset(reset), .req_valid(v1), .req_ready(r1), .req_we(we), .req_addr(a),
        .req_size(sz), .req_sign(sg), .req_wdata(wd), .req_pc(pc), .resp_valid(rv1),
        .resp_rdata(d1), .resp_exc(e1));
    dm_sized #(.ADDR_W(14), .LATENCY(3), .TRACE(0)) u3 (
        .clk(clk), .reset(reset), .req_valid(v3), .req_ready(r3), .req_we(we), .req_addr(a),
        .req_size(sz), .req_sign(sg), .req_wdata(wd), .req_pc(pc), .resp_valid(rv3),
        .resp_rdata(d3), .resp_exc(e3));

    function automatic void model(input bit l3, input bit w, input logic [31:0] ad, input logic [1:0] s,
                                  input bit g, input logic [31:0] dat, output logic [31:0] rd, output bit ex);
        int n = s == 0 ? 1 : s == 1 ? 2 : 4;
        longint v = 0;
        ex = s == 3 || (ad % n) != 0 || ad >= 16384;
        rd = 0;
        if (ex) return;
        for (int k = 0; k < n; k++)
            if (w) begin
                if (l3) m3[ad+k] = dat[8*k+:8]; else m1[ad+k] = dat[8*k+:8];
            end else
                v = v | (longint'(l3 ? m3[ad+k] : m1[ad+k]) << (8 * k));
        if (!w && g && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8 * n));
        if (!w) rd = v[31:0];
    endfunction

    function automatic void clear_model();
        for (int i = 0; i < 16384; i++) begin
            m1[i] = 0;
            m3[i] = 0;
        end
    endfunction

    task automatic xact(input bit l3, input bit w, input logic [31:0] ad, input logic [1:0] s, input bit g,
                        input logic [31:0] dat, output logic [31:0] rd, output bit ex, output int lat);
        int t = 0;
        @(negedge clk);
        we = w; a = ad; sz = s; sg = g; wd = dat; pc = pc + 4;
        while (!(l3 ? r3 : r1) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (l3) v3 = 1; else v1 = 1;
        @(posedge clk); #1;
        v1 = 0; v3 = 0; lat = 0;
        while (!(l3 ? rv3 : rv1) && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = l3 ? d3 : d1;
        ex = l3 ? e3 : e1;
    endtask

    task automatic test_reset();
        clear_model();
        reset = 1; v1 = 1; we = 1; a = 32'h40; sz = 2; wd = 32'hFFFFFFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (r1 !== 1'b0 || r3 !== 1'b0) begin
            bad++;
            $display("FAIL ready_in_reset got=%b%b exp=00", r1, r3);
        end
        v1 = 0; reset = 0;
        @(posedge clk); #1;
        total++;
        if ({r1, r3, rv1, rv3, e1, e3} !== 6'b110000 || d1 !== 0 || d3 !== 0) begin
            bad++;
            $display("FAIL reset_state got=%b d1=%h d3=%h exp=110000 0 0", {r1, r3, rv1, rv3, e1, e3}, d1, d3);
        end
    endtask

    typedef struct {
        bit w; logic [31:0] a; logic [1:0] s; bit g; logic [31:0] wd; logic [31:0] er; bit ee;
    } op_t;

    task automatic test_plan();
        op_t plan [18] = '{
            '{0, 32'h00, 2, 0, 0, 32'h00000000, 0}, '{0, 32'h40, 2, 0, 0, 32'h00000000, 0},
            '{1, 32'h10, 2, 0, 32'h12345678, 0, 0}, '{1, 32'h11, 0, 0, 32'h000000AB, 0, 0},
            '{0, 32'h10, 2, 0, 0, 32'h1234AB78, 0}, '{0, 32'h11, 0, 1, 0, 32'hFFFFFFAB, 0},
            '{0, 32'h11, 0, 0, 0, 32'h000000AB, 0}, '{1, 32'h22, 1, 0, 32'h00008001, 0, 0},
            '{0, 32'h20, 2, 0, 0, 32'h80010000, 0}, '{0, 32'h22, 1, 1, 0, 32'hFFFF8001, 0},
            '{0, 32'h22, 1, 0, 0, 32'h00008001, 0}, '{0, 32'h13, 2, 0, 0, 32'h00000000, 1},
            '{1, 32'h21, 1, 0, 32'h0000FFFF, 0, 1}, '{0, 32'h20, 3, 0, 0, 32'h00000000, 1},
            '{0, 32'h4000, 2, 0, 0, 32'h00000000, 1}, '{1, 32'h4000, 2, 0, 32'hCAFEF00D, 0, 1},
            '{0, 32'h00, 2, 0, 0, 32'h00000000, 0}, '{0, 32'h20, 2, 0, 0, 32'h80010000, 0}};
        logic [31:0] rd, mr;
        bit ex, me;
        int lat;
        foreach (plan[i]) begin
            xact(0, plan[i].w, plan[i].a, plan[i].s, plan[i].g, plan[i].wd, rd, ex, lat);
            model(0, plan[i].w, plan[i].a, plan[i].s, plan[i].g, plan[i].wd, mr, me);
            total++;
            if (rd !== plan[i].er || ex !== plan[i].ee || lat !== 0) begin
                bad++;
                $display("FAIL plan[%0d] got rd=%h exc=%b lat=%0d exp rd=%h exc=%b lat=0",
                         i, rd, ex, lat, plan[i].er, plan[i].ee);
            end
        end
    endtask

    task automatic test_random(input bit l3, input int n);
        logic [31:0] rd, mr, ad, dat;
        logic [1:0] s;
        bit ex, me, w, g;
        int lat;
        for (int i = 0; i < n; i++) begin
            s = 2'($urandom_range(0, 3));
            ad = $urandom_range(0, 63);
            if ($urandom_range(0, 15) == 0) ad = ad | (32'h1 << $urandom_range(14, 31));
            if ($urandom_range(0, 3) != 0) ad = s == 1 ? {ad[31:1], 1'b0} : s == 2 ? {ad[31:2], 2'b00} : ad;
            w = $urandom_range(0, 2) == 0;
            g = 1'($urandom_range(0, 1));
            dat = $urandom;
            xact(l3, w, ad, s, g, dat, rd, ex, lat);
            model(l3, w, ad, s, g, dat, mr, me);
            total++;
            if (rd !== mr || ex !== me || lat !== (l3 ? 2 : 0)) begin
                bad++;
                $display("FAIL rand%0d[%0d] we=%b a=%h sz=%0d got rd=%h exc=%b lat=%0d exp rd=%h exc=%b lat=%0d",
                         l3 ? 3 : 1, i, w, ad, s, rd, ex, lat, mr, me, l3 ? 2 : 0);
            end
        end
    endtask

    task automatic test_latency3();
        logic [31:0] mr;
        bit me;
        @(negedge clk);
        we = 0; a = 32'h0; sz = 2; sg = 0; v3 = 1;
        @(posedge clk); #1;
        v3 = 0;
        model(1, 0, 32'h0, 2, 0, 0, mr, me);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (r3 !== 1'b0 || rv3 !== 1'b0) begin
                bad++;
                $display("FAIL lat3_busy%0d got ready=%b valid=%b exp 0 0", k, r3, rv3);
            end
            @(posedge clk); #1;
        end
        total++;
        if (r3 !== 1'b1 || rv3 !== 1'b1 || d3 !== mr || e3 !== me) begin
            bad++;
            $display("FAIL lat3_resp got ready=%b valid=%b rd=%h exc=%b exp 1 1 %h %b", r3, rv3, d3, e3, mr, me);
        end
        @(posedge clk); #1;
        total++;
        if (rv3 !== 1'b0 || r3 !== 1'b1) begin
            bad++;
            $display("FAIL lat3_pulse got valid=%b ready=%b exp 0 1", rv3, r3);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, mr;
        bit ex, me;
        int lat;
        xact(1, 1, 32'h30, 2, 0, 32'h11223344, rd, ex, lat);
        model(1, 1, 32'h30, 2, 0, 32'h11223344, mr, me);
        xact(1, 0, 32'h30, 2, 0, 0, rd, ex, lat);
        model(1, 0, 32'h30, 2, 0, 0, mr, me);
        total++;
        if (rd !== 32'h11223344 || ex !== 1'b0 || lat !== 2) begin
            bad++;
            $display("FAIL b2b_first got rd=%h exc=%b lat=%0d exp 11223344 0 2", rd, ex, lat);
        end
        @(negedge clk);
        we = 0; a = 32'h31; sz = 0; sg = 0;
        total++;
        if (r3 !== 1'b1 || rv3 !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready got ready=%b valid=%b exp 1 1", r3, rv3);
        end
        v3 = 1;
        @(posedge clk); #1;
        v3 = 0;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (rv3 !== 1'b0 || d3 !== 32'h11223344) begin
                bad++;
                $display("FAIL b2b_hold%0d got valid=%b rd=%h exp 0 11223344", k, rv3, d3);
            end
            @(posedge clk); #1;
        end
        model(1, 0, 32'h31, 0, 0, 0, mr, me);
        total++;
        if (rv3 !== 1'b1 || d3 !== mr || e3 !== me) begin
            bad++;
            $display("FAIL b2b_second got valid=%b rd=%h exc=%b exp 1 %h %b", rv3, d3, e3, mr, me);
        end
    endtask

    task automatic test_reset_busy();
        logic [31:0] rd;
        bit ex, seen = 0;
        int lat;
        @(negedge clk);
        we = 1; a = 32'h8; sz = 2; wd = 32'hDEADBEEF; v3 = 1;
        @(posedge clk); #1;
        v3 = 0;
        @(negedge clk);
        reset = 1;
        @(posedge clk); #1;
        seen = rv3;
        @(negedge clk);
        reset = 0;
        clear_model();
        repeat (5) begin
            @(posedge clk); #1;
            seen = seen | rv3;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy_pulse got valid=%b exp 0", seen);
        end
        xact(1, 0, 32'h8, 2, 0, 0, rd, ex, lat);
        total++;
        if (rd !== 32'h0 || ex !== 1'b0 || lat !== 2) begin
            bad++;
            $display("FAIL reset_busy_mem got rd=%h exc=%b lat=%0d exp 00000000 0 2", rd, ex, lat);
        end
        xact(0, 0, 32'h10, 2, 0, 0, rd, ex, lat);
        total++;
        if (rd !== 32'h0 || ex !== 1'b0 || lat !== 0) begin
            bad++;
            $display("FAIL reset_clear_l1 got rd=%h exc=%b lat=%0d exp 00000000 0 0", rd, ex, lat);
        end
    endtask

    initial begin
        test_reset();
        test_plan();
        test_random(0, 300);
        test_latency3();
        test_back_to_back();
        test_random(1, 100);
        test_reset_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
